// File: rtl/spi_slave_core.sv
// spi_slave_core: MMIO SPI responder; synchronizes external SCLK/MOSI/SS_N
// into clk and shifts bytes MSB-first in all four CPOL/CPHA modes.
module spi_slave_core #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_ss_n,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        rx_irq
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
  logic sclk_prev_q, ss_prev_q;
  logic cpol_q, cpol_d, cpha_q, cpha_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d, tx_buf_q, tx_buf_d;
  logic rx_valid_q, rx_valid_d, ovr_q, ovr_d, tx_full_q, tx_full_d;
  logic load_pend_q, load_pend_d;
  logic sclk_s, mosi_s, ss_s, busy;
  logic leading, trailing, ss_fall, ss_rise;
  logic start, stop, samp, shft, done, tx_load;
  logic wr_tx, wr_ctrl, wr_clr;
  logic unused;
  assign unused = ^{read, addr[4:2], wr_data[31:8]};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
    end
  end
  assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign leading  = (sclk_s ^ sclk_prev_q) & (sclk_s != cpol_q);
  assign trailing = (sclk_s ^ sclk_prev_q) & (sclk_s == cpol_q);
  assign ss_fall  = ss_prev_q & ~ss_s;
  assign ss_rise  = ~ss_prev_q & ss_s;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && ss_fall)   state_d = ACTIVE;
    if (state_q == ACTIVE && ss_rise) state_d = IDLE;
  end
  always_comb busy = (state_q == ACTIVE);
  // A deselect wins over any SCLK edge seen in the same cycle
  assign start   = ~busy & ss_fall;
  assign stop    = busy & ss_rise;
  assign samp    = busy & ~ss_rise & (cpha_q ? trailing : leading);
  assign shft    = busy & ~ss_rise & (cpha_q ? leading : trailing);
  assign done    = samp & (bit_cnt_q == 3'd7);
  assign tx_load = cpha_q ? (shft & (bit_cnt_q == 3'd0)) : (start | (shft & load_pend_q));
  assign wr_tx   = cs & write & (addr[1:0] == 2'd1);
  assign wr_ctrl = cs & write & (addr[1:0] == 2'd2);
  assign wr_clr  = cs & write & (addr[1:0] == 2'd3);
  always_comb begin
    bit_cnt_d   = (start | stop | done) ? 3'd0 : samp ? bit_cnt_q + 3'd1 : bit_cnt_q;
    load_pend_d = (start | stop) ? 1'b0 : done ? 1'b1 : shft ? 1'b0 : load_pend_q;
    rx_shift_d  = samp ? {rx_shift_q[6:0], mosi_s} : rx_shift_q;
    rx_data_d   = done ? {rx_shift_q[6:0], mosi_s} : rx_data_q;
    rx_valid_d  = done ? 1'b1 : (wr_clr & wr_data[0]) ? 1'b0 : rx_valid_q;
    ovr_d       = (done & rx_valid_q & ~(wr_clr & wr_data[0])) ? 1'b1 :
                  (wr_clr & wr_data[1]) ? 1'b0 : ovr_q;
    tx_shift_d  = tx_load ? (tx_full_q ? tx_buf_q : 8'h00) :
                  shft ? {tx_shift_q[6:0], 1'b0} : tx_shift_q;
    tx_buf_d    = wr_tx ? wr_data[7:0] : tx_buf_q;
    tx_full_d   = wr_tx ? 1'b1 : tx_load ? 1'b0 : tx_full_q;
    cpol_d      = wr_ctrl ? wr_data[0] : cpol_q;
    cpha_d      = wr_ctrl ? wr_data[1] : cpha_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q   <= '0;
      load_pend_q <= 1'b0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      ovr_q       <= 1'b0;
      tx_shift_q  <= '0;
      tx_buf_q    <= '0;
      tx_full_q   <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      load_pend_q <= load_pend_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      ovr_q       <= ovr_d;
      tx_shift_q  <= tx_shift_d;
      tx_buf_q    <= tx_buf_d;
      tx_full_q   <= tx_full_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
    end
  end
  assign spi_miso_oe = ~ss_s;
  assign spi_miso    = tx_shift_q[7] & spi_miso_oe;
  assign rx_irq      = rx_valid_q;
  always_comb
    rd_data = (addr[1:0] == 2'd0) ? {20'b0, busy, ovr_q, tx_full_q, rx_valid_q, rx_data_q} :
              (addr[1:0] == 2'd2) ? {30'b0, cpha_q, cpol_q} : 32'd0;
endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: directed bench driving a behavioural SPI master against
// the responder, with queued expectations for MISO and received bytes.
module tb_spi_slave_core;
  logic clk = 1'b0, reset_n = 1'b0;
  logic cs = 1'b0, read = 1'b0, write = 1'b0;
  logic [4:0] addr = '0;
  logic [31:0] wr_data = '0, rd_data;
  logic spi_sclk = 1'b0, spi_mosi = 1'b0, spi_ss_n = 1'b1;
  logic spi_miso, spi_miso_oe, rx_irq;
  int checks = 0, errors = 0;
  int hp = 8;
  logic m_cpol = 1'b0, m_cpha = 1'b0;
  logic [7:0] exp_miso[$], exp_rx[$];
  logic [7:0] got;
  spi_slave_core #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .rx_irq(rx_irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = {3'b0, a}; wr_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0;
  endtask
  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    @(negedge clk);
    cs = 1'b1; read = 1'b1; addr = {3'b0, a};
    #1 d = rd_data;
    cs = 1'b0; read = 1'b0;
    chk(tag, d, exp);
  endtask
  task automatic pop_miso(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    e = (exp_miso.size() > 0) ? exp_miso.pop_front() : 8'hxx;
    chk(tag, {24'b0, obs}, {24'b0, e});
  endtask
  task automatic pop_rx(input string tag);
    logic [7:0] e;
    logic [31:0] d;
    e = (exp_rx.size() > 0) ? exp_rx.pop_front() : 8'hxx;
    @(negedge clk);
    addr = 5'd0;
    #1 d = rd_data;
    chk(tag, {24'b0, d[7:0]}, {24'b0, e});
  endtask
  task automatic set_mode(input logic [1:0] m);
    wr(2'd2, {30'b0, m});
    m_cpol = m[0]; m_cpha = m[1];
    spi_sclk = m_cpol;
    repeat (4) @(negedge clk);
  endtask
  task automatic ss_low();
    @(negedge clk);
    spi_ss_n = 1'b0;
    repeat (hp) @(negedge clk);
    chk("oe_selected", {31'b0, spi_miso_oe}, 32'd1);
  endtask
  task automatic ss_high();
    repeat (hp) @(negedge clk);
    spi_ss_n = 1'b1;
    repeat (2 * hp) @(negedge clk);
  endtask
  task automatic xbyte(input logic [7:0] d, input int n, output logic [7:0] q);
    q = '0;
    for (int i = 0; i < n; i++) begin
      if (!m_cpha) begin
        spi_mosi = d[7-i];
        repeat (hp) @(negedge clk);
        spi_sclk = ~m_cpol;
        q = {q[6:0], spi_miso};
        repeat (hp) @(negedge clk);
        spi_sclk = m_cpol;
      end else begin
        spi_sclk = ~m_cpol;
        spi_mosi = d[7-i];
        repeat (hp) @(negedge clk);
        spi_sclk = m_cpol;
        q = {q[6:0], spi_miso};
        repeat (hp) @(negedge clk);
      end
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_rd("rst_addr0", 2'd0, 32'h0);
    chk_rd("rst_addr1", 2'd1, 32'h0);
    chk_rd("rst_ctrl", 2'd2, 32'h0);
    chk_rd("rst_addr3", 2'd3, 32'h0);
    chk("rst_miso", {31'b0, spi_miso}, 32'd0);
    chk("rst_oe", {31'b0, spi_miso_oe}, 32'd0);
    chk("rst_irq", {31'b0, rx_irq}, 32'd0);
    // mode 0 single byte
    set_mode(2'd0);
    wr(2'd1, 32'hA5);
    exp_miso.push_back(8'hA5);
    exp_rx.push_back(8'h3C);
    ss_low();
    xbyte(8'h3C, 8, got);
    pop_miso("m0_miso", got);
    pop_rx("m0_rx");
    ss_high();
    chk_rd("m0_addr0", 2'd0, 32'h13C);
    chk("m0_irq", {31'b0, rx_irq}, 32'd1);
    wr(2'd3, 32'h1);
    // modes 1..3
    for (int m = 1; m < 4; m++) begin
      set_mode(m[1:0]);
      chk_rd("ctrl_rd", 2'd2, m);
      wr(2'd1, 32'h81);
      exp_miso.push_back(8'h81);
      exp_rx.push_back(8'h7E);
      ss_low();
      xbyte(8'h7E, 8, got);
      pop_miso("mode_miso", got);
      pop_rx("mode_rx");
      ss_high();
      chk_rd("mode_addr0", 2'd0, 32'h17E);
      wr(2'd3, 32'h1);
    end
    // two bytes in one select; second byte finds tx_buf empty
    set_mode(2'd0);
    wr(2'd1, 32'hC3);
    exp_miso.push_back(8'hC3);
    exp_miso.push_back(8'h00);
    exp_rx.push_back(8'h11);
    exp_rx.push_back(8'h22);
    ss_low();
    xbyte(8'h11, 8, got);
    pop_miso("b2b_miso0", got);
    pop_rx("b2b_rx0");
    xbyte(8'h22, 8, got);
    pop_miso("b2b_miso1", got);
    pop_rx("b2b_rx1");
    ss_high();
    chk_rd("ovr_addr0", 2'd0, 32'h522);
    wr(2'd3, 32'h3);
    chk_rd("clr_addr0", 2'd0, 32'h022);
    chk("clr_irq", {31'b0, rx_irq}, 32'd0);
    // deselect after 5 bits
    ss_low();
    xbyte(8'hFF, 5, got);
    ss_high();
    chk_rd("partial_addr0", 2'd0, 32'h022);
    exp_miso.push_back(8'h00);
    exp_rx.push_back(8'h5A);
    ss_low();
    xbyte(8'h5A, 8, got);
    pop_miso("after_partial_miso", got);
    pop_rx("after_partial_rx");
    ss_high();
    chk_rd("after_partial_addr0", 2'd0, 32'h15A);
    wr(2'd3, 32'h1);
    // reset mid-byte
    set_mode(2'd3);
    wr(2'd1, 32'h99);
    ss_low();
    xbyte(8'hF0, 4, got);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_oe", {31'b0, spi_miso_oe}, 32'd0);
    chk("mid_rst_miso", {31'b0, spi_miso}, 32'd0);
    chk("mid_rst_irq", {31'b0, rx_irq}, 32'd0);
    chk_rd("mid_rst_addr0", 2'd0, 32'h0);
    chk_rd("mid_rst_ctrl", 2'd2, 32'h0);
    spi_ss_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    m_cpol = 1'b0; m_cpha = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_rd("post_rst_addr0", 2'd0, 32'h0);
    wr(2'd1, 32'h3C);
    exp_miso.push_back(8'h3C);
    exp_rx.push_back(8'hC3);
    ss_low();
    xbyte(8'hC3, 8, got);
    pop_miso("post_rst_miso", got);
    pop_rx("post_rst_rx");
    ss_high();
    chk_rd("post_rst_final", 2'd0, 32'h1C3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
